// File: rtl/mac_share_ctrl.sv
// Round-robin controller that time-shares one external multiply-accumulate unit
// between two requesters, each streaming a dot product of len element pairs.
module mac_share_ctrl #(
    parameter int W     = 10,
    parameter int ACC_W = 20,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [W-1:0]     x0,
    input  logic [W-1:0]     y0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     y1,
    input  logic             valid1,
    output logic             ready1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic [ACC_W-1:0] result,
    output logic [W-1:0]     mac_x,
    output logic [W-1:0]     mac_y,
    output logic             mac_enable,
    output logic             mac_clear,
    input  logic [ACC_W-1:0] mac_sum
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic               owner_r;
    logic               prio_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   count_r;
    logic [1:0]         grant_r;
    logic [1:0]         done_r;
    logic               ready0_r;
    logic               ready1_r;
    logic               clear_r;
    logic [ACC_W-1:0]   result_r;
    logic               pick_s;
    logic [LEN_W-1:0]   pick_len_s;
    logic               accept_s;

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

    // Arbitration: a lone request wins, a tie goes to the round-robin favourite.
    always_comb begin
        pick_s = prio_r;
        case (req)
            2'b01:   pick_s = 1'b0;
            2'b10:   pick_s = 1'b1;
            default: pick_s = prio_r;
        endcase
        pick_len_s = pick_s ? len1 : len0;
    end

    // ready is only ever high for the owner in ACCUM, so enable doubles as accept.
    assign accept_s   = (ready0_r & valid0) | (ready1_r & valid1);
    assign mac_enable = accept_s;
    assign mac_clear  = clear_r | reset;
    assign mac_x      = owner_r ? x1 : x0;
    assign mac_y      = owner_r ? y1 : y0;
    assign grant      = grant_r;
    assign done       = done_r;
    assign ready0     = ready0_r;
    assign ready1     = ready1_r;
    assign result     = result_r;

    // Transaction sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            owner_r  <= 1'b0;
            prio_r   <= 1'b0;
            len_r    <= '0;
            count_r  <= '0;
            grant_r  <= 2'b00;
            done_r   <= 2'b00;
            ready0_r <= 1'b0;
            ready1_r <= 1'b0;
            clear_r  <= 1'b0;
            result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 2'b00;
                    if (req != 2'b00) begin
                        owner_r <= pick_s;
                        len_r   <= pick_len_s;
                        count_r <= '0;
                        grant_r <= onehot2(pick_s);
                        clear_r <= 1'b1;
                        state_r <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clear_r <= 1'b0;
                    if (len_r != '0) begin
                        ready0_r <= ~owner_r;
                        ready1_r <= owner_r;
                        state_r  <= ST_ACCUM;
                    end else begin
                        state_r  <= ST_DRAIN;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        count_r <= count_r + LEN_ONE;
                        if (count_r == len_r - LEN_ONE) begin
                            ready0_r <= 1'b0;
                            ready1_r <= 1'b0;
                            state_r  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // MAC register already includes the final beat here.
                    result_r <= mac_sum;
                    done_r   <= onehot2(owner_r);
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 2'b00;
                    prio_r  <= ~owner_r;
                    grant_r <= 2'b00;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant_r  <= 2'b00;
                    done_r   <= 2'b00;
                    ready0_r <= 1'b0;
                    ready1_r <= 1'b0;
                    clear_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
